serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 99 +++++++++
 tb/tb_serial_add_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-add cell (two half adders plus a
// carry flop) stepped LSB-first over a WIDTH-bit operand pair, one bit per clock.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // WIDTH is at most 32, so six bits always hold the bit index
  localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [5:0]       cnt_q, cnt_d;

  logic ha1_p, ha1_g, ha2_s, ha2_t, carry_nxt;

  assign ha1_p     = a_sh_q[0] ^ b_sh_q[0];
  assign ha1_g     = a_sh_q[0] & b_sh_q[0];
  assign ha2_s     = ha1_p ^ carry_q;
  assign ha2_t     = ha1_p & carry_q;
  assign carry_nxt = ha1_g | ha2_t;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so bit 0 ends up in sum[0] after WIDTH steps
        sum_d   = (sum_q >> 1) | (WIDTH'(ha2_s) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == LAST_BIT) begin
          cout_d  = carry_nxt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decoded straight from the state so reset clears it without a clock
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized bench for serial_add_ctrl at WIDTH = 8, 1 and 16,
// checked against plain integer addition and handshake timing expectations.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        start16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_add_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_add_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  int n_assert = 0;
  int n_fail   = 0;

  logic        ob, od, oc;
  logic [31:0] os;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [31:0] av, input logic [31:0] bv, input logic st);
    case (w)
      1:       begin a1 = av[0:0]; b1 = bv[0:0]; start1 = st; end
      16:      begin a16 = av[15:0]; b16 = bv[15:0]; start16 = st; end
      default: begin a8 = av[7:0]; b8 = bv[7:0]; start8 = st; end
    endcase
  endtask

  task automatic samp(input int w);
    case (w)
      1:       begin ob = busy1;  od = done1;  os = 32'(sum1);  oc = cout1;  end
      16:      begin ob = busy16; od = done16; os = 32'(sum16); oc = cout16; end
      default: begin ob = busy8;  od = done8;  os = 32'(sum8);  oc = cout8;  end
    endcase
  endtask

  // One addition through the handshake; with hold=1, start stays high (with
  // different operands) through RUN and DONE and must be ignored.
  task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                    input bit hold, input string tag);
    logic [32:0] total, mask;
    int n, nb;
    total = 33'(av) + 33'(bv);
    mask  = (33'd1 << w) - 33'd1;
    drive(w, av, bv, 1'b1);
    @(posedge clk); #1;
    if (hold) drive(w, 32'd99, 32'd99, 1'b1);
    else      drive(w, 32'd0, 32'd0, 1'b0);
    samp(w);
    chk({tag, " busy_after_accept"}, 33'(ob), 33'd1);
    n = 1;
    nb = ob ? 1 : 0;
    while (!od && n < 60) begin
      @(posedge clk); #1;
      n++;
      samp(w);
      if (ob) nb++;
      chk({tag, " busy_done_overlap"}, 33'(ob & od), 33'd0);
    end
    chk({tag, " edges_to_done"}, 33'(n), 33'(w + 1));
    chk({tag, " busy_cycles"}, 33'(nb), 33'(w));
    chk({tag, " sum"}, 33'(os), total & mask);
    chk({tag, " cout"}, 33'(oc), (total >> w) & 33'd1);
    @(posedge clk); #1;
    samp(w);
    chk({tag, " done_one_cycle"}, 33'(od), 33'd0);
    chk({tag, " idle_after_done"}, 33'(ob), 33'd0);
    drive(w, 32'd0, 32'd0, 1'b0);
    if (hold) begin
      repeat (3) begin
        @(posedge clk); #1;
        samp(w);
        chk({tag, " no_rerun_busy"}, 33'(ob | od), 33'd0);
      end
      chk({tag, " sum_held"}, 33'(os), total & mask);
    end
  endtask

  logic [32:0] exp_q[$];
  logic [32:0] e;
  int cyc, last_acc, ndone;
  logic prev_busy;

  initial begin
    drive(8, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(16, 0, 0, 0);
    #2;
    samp(8);
    chk("reset busy", 33'(ob), 33'd0);
    chk("reset done", 33'(od), 33'd0);
    chk("reset sum", 33'(os), 33'd0);
    chk("reset cout", 33'(oc), 33'd0);
    #20 rst_n = 1'b1;

    op(8, 3, 5, 0, "w8_3p5");
    op(8, 255, 1, 0, "w8_255p1");
    op(8, 200, 100, 0, "w8_200p100");
    op(8, 10, 20, 1, "w8_start_ignored");

    for (int i = 0; i < 4; i++)
      op(1, 32'(i >> 1), 32'(i & 1), 0, $sformatf("w1_%0d%0d", i >> 1, i & 1));

    // Asynchronous reset in the middle of a run
    drive(8, 170, 85, 1'b1);
    @(posedge clk); #1;
    drive(8, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    samp(8);
    chk("abort busy", 33'(ob), 33'd0);
    chk("abort done", 33'(od), 33'd0);
    chk("abort sum", 33'(os), 33'd0);
    chk("abort cout", 33'(oc), 33'd0);
    repeat (2) begin
      @(posedge clk); #1;
      samp(8);
      chk("abort no_done", 33'(od | ob), 33'd0);
    end
    #3 rst_n = 1'b1;
    op(8, 1, 1, 0, "w8_after_abort");

    // Start held high continuously with fresh random operands after each accept
    drive(16, $urandom, $urandom, 1'b1);
    cyc = 0; last_acc = -1; ndone = 0; prev_busy = 1'b0;
    while (ndone < 20 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (busy16 && !prev_busy) begin
        exp_q.push_back(33'(a16) + 33'(b16));
        if (last_acc >= 0) chk("w16 accept_spacing", 33'(cyc - last_acc), 33'd18);
        last_acc = cyc;
        drive(16, $urandom, $urandom, 1'b1);
      end
      if (done16) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("w16 rand%0d", ndone), {16'd0, cout16, sum16}, e);
        end else begin
          chk("w16 unexpected_done", 33'd1, 33'd0);
        end
        ndone++;
      end
      prev_busy = busy16;
    end
    chk("w16 done_count", 33'(ndone), 33'd20);
    drive(16, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
